call_seq: RTL and testbench

CALL_SEQ -- requirements
Module: call_seq

---
 rtl/acct_pkg.sv | 41 ++++
 rtl/call_min_timer.sv | 32 +++
 rtl/call_seq.sv | 150 +++++++++++++++
 tb/tb_call_seq.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acct_pkg.sv
// acct_pkg: shared types and constants for the phone-card call sequencer.
// Holds the FSM state enum, dialled-category codes, per-minute rates,
// the low-balance warning thresholds (two minutes' worth of charge) and a
// saturating 2-digit BCD increment used by the minute display.
package acct_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_READY  = 3'd2,
    ST_CHARGE = 3'd3,
    ST_TALK   = 3'd4,
    ST_CUT    = 3'd5,
    ST_WRITE  = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  localparam logic [1:0] CAT_NONE    = 2'b00;
  localparam logic [1:0] CAT_LOCAL   = 2'b01;
  localparam logic [1:0] CAT_LONG    = 2'b10;
  localparam logic [1:0] CAT_INVALID = 2'b11;

  // BCD, units of 0.1 yuan
  localparam logic [11:0] RATE_LOCAL = 12'h003;
  localparam logic [11:0] RATE_LONG  = 12'h010;
  localparam logic [11:0] WARN_LOCAL = 12'h006;
  localparam logic [11:0] WARN_LONG  = 12'h020;

  // Two-digit BCD increment that sticks at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = v;
    else if (v[3:0] == 4'h9)
      r = {v[7:4] + 4'h1, 4'h0};
    else
      r = {v[7:4], v[3:0] + 4'h1};
    return r;
  endfunction

endpackage

// File: rtl/call_min_timer.sv
// call_min_timer: billed-minute tick counter.
// Counts 0..TICKS-1 while enable is high and raises tc for the single cycle
// in which the count sits at TICKS-1. clear has priority and returns the
// count to 0.
// Ports: clk_1kHz, clrn (async active-low), clear, enable -> tc.
module call_min_timer #(
  parameter int unsigned TICKS = 60000
) (
  input  logic clk_1kHz,
  input  logic clrn,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] LAST = W'(TICKS - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_1kHz or negedge clrn) begin
    if (!clrn)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tc = enable && (cnt == LAST);

endmodule

// File: rtl/call_seq.sv
// call_seq: phone-card call sequencer.
// Reads the card, waits for a valid dialled category, charges one minute at
// connect and then one per TICKS_PER_MIN cycles of talk, warns when less
// than two minutes of balance remain, cuts the line when the balance cannot
// cover a minute, and writes the card back when the call ends.
// Ports: clk_1kHz, clrn (async active-low); card, on, category, bal,
// charge_ack in; charge_req/charge_amt deduction handshake, read/write/
// time_clr strobes, talk_min (BCD), warn, cut, speaker, state out.
//
// state     | meaning
// ST_IDLE   | no card
// ST_READ   | one-cycle card read, clears the call-time display
// ST_READY  | card read, waiting for a connected valid call
// ST_CHARGE | requesting one minute's deduction
// ST_TALK   | call in progress, timing the billed minute
// ST_CUT    | balance exhausted, line cut until hang-up/card removal
// ST_WRITE  | one-cycle card write-back
// ST_DONE   | waiting for card removal
module call_seq
  import acct_pkg::*;
#(
  parameter int unsigned TICKS_PER_MIN = 60000
) (
  input  logic        clk_1kHz,
  input  logic        clrn,
  input  logic        card,
  input  logic        on,
  input  logic [1:0]  category,
  input  logic [11:0] bal,
  input  logic        charge_ack,
  output logic        charge_req,
  output logic [11:0] charge_amt,
  output logic        read,
  output logic        write,
  output logic        time_clr,
  output logic [7:0]  talk_min,
  output logic        warn,
  output logic        cut,
  output logic        speaker,
  output logic [2:0]  state
);

  state_t      st, st_nxt;
  logic [11:0] rate;
  logic        is_long;
  logic [7:0]  min_cnt;
  logic [1:0]  tone_div;
  logic        tc;
  logic        drop;
  logic        short_bal;
  logic        ack_take;

  assign drop = !on || !card;
  // Valid BCD orders the same as plain binary, so an unsigned compare is the
  // numeric compare.
  assign short_bal = bal < rate;

  call_min_timer #(.TICKS(TICKS_PER_MIN)) u_min_timer (
    .clk_1kHz (clk_1kHz),
    .clrn     (clrn),
    .clear    (st != ST_TALK),
    .enable   (st == ST_TALK),
    .tc       (tc)
  );

  always_ff @(posedge clk_1kHz or negedge clrn) begin
    if (!clrn) begin
      st       <= ST_IDLE;
      rate     <= 12'h000;
      is_long  <= 1'b0;
      min_cnt  <= 8'h00;
      tone_div <= 2'd0;
    end else begin
      st       <= st_nxt;
      tone_div <= tone_div + 2'd1;
      if (st == ST_READY && st_nxt == ST_CHARGE) begin
        is_long <= (category == CAT_LONG);
        rate    <= (category == CAT_LONG) ? RATE_LONG : RATE_LOCAL;
      end
      if (st == ST_READ)
        min_cnt <= 8'h00;
      else if (ack_take)
        min_cnt <= bcd_inc_sat(min_cnt);
    end
  end

  always_comb begin
    st_nxt     = st;
    read       = 1'b0;
    write      = 1'b0;
    time_clr   = 1'b0;
    charge_req = 1'b0;
    cut        = 1'b0;
    ack_take   = 1'b0;
    case (st)
      ST_IDLE:   if (card) st_nxt = ST_READ;
      ST_READ: begin
        read     = 1'b1;
        time_clr = 1'b1;
        st_nxt   = ST_READY;
      end
      ST_READY: begin
        if (!card)
          st_nxt = ST_IDLE;
        else if (on && (category == CAT_LOCAL || category == CAT_LONG))
          st_nxt = ST_CHARGE;
      end
      ST_CHARGE: begin
        // Hang-up beats everything; the request vanishes in the same cycle so
        // an ack arriving with or after the drop is never honoured.
        if (drop)
          st_nxt = ST_WRITE;
        else if (short_bal)
          st_nxt = ST_CUT;
        else begin
          charge_req = 1'b1;
          if (charge_ack) begin
            ack_take = 1'b1;
            st_nxt   = ST_TALK;
          end
        end
      end
      ST_TALK: begin
        if (drop)
          st_nxt = ST_WRITE;
        else if (tc)
          st_nxt = ST_CHARGE;
      end
      ST_CUT: begin
        cut = 1'b1;
        if (drop) st_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        write  = 1'b1;
        st_nxt = ST_DONE;
      end
      ST_DONE:   if (!card) st_nxt = ST_IDLE;
      default:   st_nxt = ST_IDLE;
    endcase
  end

  assign charge_amt = charge_req ? rate : 12'h000;
  assign talk_min   = min_cnt;
  assign warn       = (st == ST_TALK || st == ST_CHARGE) &&
                      (bal < (is_long ? WARN_LONG : WARN_LOCAL));
  // tone_div[1] toggles every two clocks: 250 Hz from the 1 kHz clock.
  assign speaker    = warn & tone_div[1];
  assign state      = st;

endmodule

// File: tb/tb_call_seq.sv
module tb_call_seq;

  logic        clk_1kHz = 1'b0;
  logic        clrn = 1'b0;
  logic        card = 1'b0;
  logic        on = 1'b0;
  logic [1:0]  category = 2'b00;
  logic [11:0] bal = 12'h000;
  logic        charge_ack = 1'b0;
  logic        charge_req;
  logic [11:0] charge_amt;
  logic        read, write, time_clr, warn, cut, speaker;
  logic [7:0]  talk_min;
  logic [2:0]  state;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_READ = 3'd1, S_READY = 3'd2, S_CHARGE = 3'd3,
                         S_TALK = 3'd4, S_CUT = 3'd5, S_WRITE = 3'd6, S_DONE = 3'd7;

  call_seq #(.TICKS_PER_MIN(100)) dut (
    .clk_1kHz   (clk_1kHz),
    .clrn       (clrn),
    .card       (card),
    .on         (on),
    .category   (category),
    .bal        (bal),
    .charge_ack (charge_ack),
    .charge_req (charge_req),
    .charge_amt (charge_amt),
    .read       (read),
    .write      (write),
    .time_clr   (time_clr),
    .talk_min   (talk_min),
    .warn       (warn),
    .cut        (cut),
    .speaker    (speaker),
    .state      (state)
  );

  always #5 clk_1kHz = ~clk_1kHz;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk_1kHz);
    #1;
  endtask

  // Advance n cycles, reporting whether the DUT stayed in TALK with no request.
  task automatic wait_talk(input int n, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (state !== S_TALK || charge_req !== 1'b0) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    cyc(); cyc();
    chk_cnt++;
    if ({charge_req, charge_amt, read, write, time_clr, talk_min, warn, cut, speaker, state} !== 30'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {charge_req, charge_amt, read, write, time_clr, talk_min, warn, cut, speaker, state});
    else pass_cnt++;
    clrn = 1'b1;
    cyc();
    chk_cnt++;
    if (state !== S_IDLE) $display("FAIL reset_release_idle: got %0d want %0d", state, S_IDLE);
    else pass_cnt++;
  endtask

  task automatic test_local_call();
    bit ok;
    card = 1'b1; category = 2'b01; bal = 12'h050; on = 1'b0;
    cyc();
    chk_cnt++;
    if ({state, read, time_clr} !== {S_READ, 2'b11})
      $display("FAIL local_read: got %h want %h", {state, read, time_clr}, {S_READ, 2'b11});
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if ({state, read, time_clr} !== {S_READY, 2'b00})
      $display("FAIL local_ready: got %h want %h", {state, read, time_clr}, {S_READY, 2'b00});
    else pass_cnt++;
    on = 1'b1;
    cyc();
    chk_cnt++;
    if ({state, charge_req, charge_amt, warn} !== {S_CHARGE, 1'b1, 12'h003, 1'b0})
      $display("FAIL local_connect_charge: got st=%0d req=%b amt=%h warn=%b want st=3 req=1 amt=003 warn=0",
               state, charge_req, charge_amt, warn);
    else pass_cnt++;
    charge_ack = 1'b1;
    cyc();
    chk_cnt++;
    if ({state, talk_min, charge_req} !== {S_TALK, 8'h01, 1'b0})
      $display("FAIL local_min1: got st=%0d min=%h req=%b want st=4 min=01 req=0", state, talk_min, charge_req);
    else pass_cnt++;
    cyc();  // ack still high while in TALK
    chk_cnt++;
    if (talk_min !== 8'h01) $display("FAIL ack_in_talk_ignored: got %h want 01", talk_min);
    else pass_cnt++;
    charge_ack = 1'b0;
    wait_talk(98, ok);
    cyc();
    chk_cnt++;
    if ({ok, state, charge_req, charge_amt} !== {1'b1, S_CHARGE, 1'b1, 12'h003})
      $display("FAIL local_minute2_timing: got ok=%b st=%0d req=%b amt=%h want ok=1 st=3 req=1 amt=003",
               ok, state, charge_req, charge_amt);
    else pass_cnt++;
    charge_ack = 1'b1;
    cyc();
    charge_ack = 1'b0;
    chk_cnt++;
    if (talk_min !== 8'h02) $display("FAIL local_min2: got %h want 02", talk_min);
    else pass_cnt++;
    wait_talk(99, ok);
    cyc();
    chk_cnt++;
    if ({ok, state, charge_req} !== {1'b1, S_CHARGE, 1'b1})
      $display("FAIL local_minute3_timing: got ok=%b st=%0d req=%b want ok=1 st=3 req=1", ok, state, charge_req);
    else pass_cnt++;
    charge_ack = 1'b1;
    cyc();
    charge_ack = 1'b0;
    chk_cnt++;
    if (talk_min !== 8'h03) $display("FAIL local_min3: got %h want 03", talk_min);
    else pass_cnt++;
    on = 1'b0;
    cyc();
    chk_cnt++;
    if ({state, write} !== {S_WRITE, 1'b1})
      $display("FAIL local_hangup_write: got st=%0d write=%b want st=6 write=1", state, write);
    else pass_cnt++;
    cyc(); cyc();
    chk_cnt++;
    if ({state, write} !== {S_DONE, 1'b0})
      $display("FAIL local_done_hold: got st=%0d write=%b want st=7 write=0", state, write);
    else pass_cnt++;
    card = 1'b0;
    cyc();
    chk_cnt++;
    if ({state, talk_min} !== {S_IDLE, 8'h03})
      $display("FAIL local_idle_min_hold: got st=%0d min=%h want st=0 min=03", state, talk_min);
    else pass_cnt++;
  endtask

  task automatic test_long_warn_cut();
    bit ok, saw0, saw1, stable;
    card = 1'b1; category = 2'b10; bal = 12'h025; on = 1'b0;
    cyc(); cyc();
    chk_cnt++;
    if ({state, talk_min} !== {S_READY, 8'h00})
      $display("FAIL long_read_clears_min: got st=%0d min=%h want st=2 min=00", state, talk_min);
    else pass_cnt++;
    on = 1'b1;
    cyc();
    chk_cnt++;
    if ({state, charge_req, charge_amt, warn} !== {S_CHARGE, 1'b1, 12'h010, 1'b0})
      $display("FAIL long_connect_charge: got st=%0d req=%b amt=%h warn=%b want st=3 req=1 amt=010 warn=0",
               state, charge_req, charge_amt, warn);
    else pass_cnt++;
    charge_ack = 1'b1;
    cyc();
    charge_ack = 1'b0;
    bal = 12'h015;
    #1;
    chk_cnt++;
    if ({state, talk_min, warn} !== {S_TALK, 8'h01, 1'b1})
      $display("FAIL long_warn_on: got st=%0d min=%h warn=%b want st=4 min=01 warn=1", state, talk_min, warn);
    else pass_cnt++;
    saw0 = 1'b0; saw1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (speaker === 1'b1) saw1 = 1'b1;
      if (speaker === 1'b0) saw0 = 1'b0 | 1'b1;
    end
    chk_cnt++;
    if ({saw0, saw1} !== 2'b11) $display("FAIL speaker_toggle: got saw0=%b saw1=%b want 1 1", saw0, saw1);
    else pass_cnt++;
    wait_talk(95, ok);
    cyc();
    chk_cnt++;
    if ({ok, state, charge_req, charge_amt, warn} !== {1'b1, S_CHARGE, 1'b1, 12'h010, 1'b1})
      $display("FAIL long_minute2_charge: got ok=%b st=%0d req=%b amt=%h warn=%b want 1 3 1 010 1",
               ok, state, charge_req, charge_amt, warn);
    else pass_cnt++;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (state !== S_CHARGE || charge_req !== 1'b1 || charge_amt !== 12'h010) stable = 1'b0;
    end
    chk_cnt++;
    if (stable !== 1'b1) $display("FAIL req_stable_no_ack: got %b want 1", stable);
    else pass_cnt++;
    charge_ack = 1'b1;
    #1;
    chk_cnt++;
    if ({charge_req, charge_amt} !== {1'b1, 12'h010})
      $display("FAIL req_during_ack: got req=%b amt=%h want 1 010", charge_req, charge_amt);
    else pass_cnt++;
    cyc();
    charge_ack = 1'b0;
    chk_cnt++;
    if ({state, charge_req, charge_amt, talk_min} !== {S_TALK, 1'b0, 12'h000, 8'h02})
      $display("FAIL req_drop_after_ack: got st=%0d req=%b amt=%h min=%h want 4 0 000 02",
               state, charge_req, charge_amt, talk_min);
    else pass_cnt++;
    bal = 12'h005;
    wait_talk(99, ok);
    cyc();
    chk_cnt++;
    if ({ok, state, charge_req} !== {1'b1, S_CHARGE, 1'b0})
      $display("FAIL low_bal_no_req: got ok=%b st=%0d req=%b want 1 3 0", ok, state, charge_req);
    else pass_cnt++;
    cyc(); cyc();
    chk_cnt++;
    if ({state, cut, charge_req} !== {S_CUT, 1'b1, 1'b0})
      $display("FAIL cut_hold: got st=%0d cut=%b req=%b want 5 1 0", state, cut, charge_req);
    else pass_cnt++;
    on = 1'b0;
    cyc();
    chk_cnt++;
    if ({state, write, cut} !== {S_WRITE, 1'b1, 1'b0})
      $display("FAIL cut_to_write: got st=%0d write=%b cut=%b want 6 1 0", state, write, cut);
    else pass_cnt++;
    cyc();
    card = 1'b0;
    cyc();
    chk_cnt++;
    if ({state, warn, speaker} !== {S_IDLE, 1'b0, 1'b0})
      $display("FAIL long_end_idle: got st=%0d warn=%b spk=%b want 0 0 0", state, warn, speaker);
    else pass_cnt++;
  endtask

  task automatic test_drop_at_tc();
    bit ok;
    card = 1'b1; category = 2'b01; bal = 12'h050; on = 1'b0;
    cyc(); cyc();
    on = 1'b1;
    cyc();
    charge_ack = 1'b1;
    cyc();
    charge_ack = 1'b0;
    wait_talk(99, ok);
    on = 1'b0;  // same cycle as the terminal count
    #1;
    chk_cnt++;
    if ({ok, state, charge_req} !== {1'b1, S_TALK, 1'b0})
      $display("FAIL tc_drop_no_req: got ok=%b st=%0d req=%b want 1 4 0", ok, state, charge_req);
    else pass_cnt++;
    cyc();
    chk_cnt++;
    if ({state, write, charge_req} !== {S_WRITE, 1'b1, 1'b0})
      $display("FAIL tc_drop_write: got st=%0d write=%b req=%b want 6 1 0", state, write, charge_req);
    else pass_cnt++;
    cyc(); cyc(); cyc();
    chk_cnt++;
    if ({state, talk_min} !== {S_DONE, 8'h01})
      $display("FAIL tc_drop_done: got st=%0d min=%h want 7 01", state, talk_min);
    else pass_cnt++;
    card = 1'b0;
    cyc();
    chk_cnt++;
    if (state !== S_IDLE) $display("FAIL tc_drop_idle: got %0d want 0", state);
    else pass_cnt++;
  endtask

  task automatic test_drop_in_charge();
    card = 1'b1; category = 2'b10; bal = 12'h050; on = 1'b0;
    cyc(); cyc();
    on = 1'b1;
    cyc();
    on = 1'b0;
    #1;
    chk_cnt++;
    if ({state, charge_req, charge_amt} !== {S_CHARGE, 1'b0, 12'h000})
      $display("FAIL charge_drop_req: got st=%0d req=%b amt=%h want 3 0 000", state, charge_req, charge_amt);
    else pass_cnt++;
    charge_ack = 1'b1;
    cyc();
    cyc();
    chk_cnt++;
    if ({state, talk_min} !== {S_DONE, 8'h00})
      $display("FAIL late_ack_ignored: got st=%0d min=%h want 7 00", state, talk_min);
    else pass_cnt++;
    charge_ack = 1'b0;
    card = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_charge();
    bit saw_write;
    card = 1'b1; category = 2'b01; bal = 12'h050; on = 1'b0;
    cyc(); cyc();
    on = 1'b1;
    cyc();
    chk_cnt++;
    if ({state, charge_req} !== {S_CHARGE, 1'b1})
      $display("FAIL pre_reset_charge: got st=%0d req=%b want 3 1", state, charge_req);
    else pass_cnt++;
    #2;
    clrn = 1'b0;
    #1;
    chk_cnt++;
    if ({charge_req, charge_amt, read, write, time_clr, talk_min, warn, cut, speaker, state} !== 30'd0)
      $display("FAIL async_reset_outputs: got %h want 0",
               {charge_req, charge_amt, read, write, time_clr, talk_min, warn, cut, speaker, state});
    else pass_cnt++;
    saw_write = 1'b0;
    card = 1'b0; on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (write !== 1'b0) saw_write = 1'b1;
    end
    clrn = 1'b1;
    cyc();
    if (write !== 1'b0) saw_write = 1'b1;
    chk_cnt++;
    if ({saw_write, state} !== {1'b0, S_IDLE})
      $display("FAIL reset_abort_no_write: got write_seen=%b st=%0d want 0 0", saw_write, state);
    else pass_cnt++;
    card = 1'b1;
    cyc();
    chk_cnt++;
    if (state !== S_READ) $display("FAIL resume_after_reset: got %0d want 1", state);
    else pass_cnt++;
    card = 1'b0;
    cyc(); cyc();
  endtask

  task automatic test_invalid_category();
    bit ok;
    card = 1'b1; category = 2'b11; bal = 12'h050; on = 1'b1;
    cyc(); cyc();
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (state !== S_READY || charge_req !== 1'b0) ok = 1'b0;
    end
    category = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (state !== S_READY || charge_req !== 1'b0) ok = 1'b0;
    end
    chk_cnt++;
    if (ok !== 1'b1) $display("FAIL invalid_cat_holds_ready: got %b want 1", ok);
    else pass_cnt++;
    card = 1'b0; on = 1'b0;
    cyc();
    chk_cnt++;
    if ({state, write} !== {S_IDLE, 1'b0})
      $display("FAIL ready_to_idle_no_write: got st=%0d write=%b want 0 0", state, write);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_local_call();
    test_long_warn_cut();
    test_drop_at_tc();
    test_drop_in_charge();
    test_reset_mid_charge();
    test_invalid_category();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
